mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.
- Successor to the single-cycle datapath's combinational ALU path: adds multi-cycle operations with a start/busy handshake, configurable width and latency, and signed/unsigned modes.
- Sits beside the ALU in the execute stage of the next-generation (pipelined) CPU.
- The hazard unit stalls on `busy` (and on `start`); HI/LO feed the mfhi/mflo writeback mux.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: cycles from accepted mult/multu to HI/LO update. Must be ≥ 1.
- DIV_CYCLES, 10: cycles from accepted div/divu to HI/LO update. Must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request qualifier; MDUOp is sampled only when start=1.
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- in_a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- in_b  input  WIDTH  rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, at rising edge with reset=1): busy=0, hi=0, lo=0, counter=0, latched operands/op cleared. Reset overrides any in-flight operation; the result is discarded.
- States: IDLE, RUN. busy=1 exactly in RUN and is registered; no combinational path from start to busy.
- IDLE, start=1, MDUOp ∈ {1..4}, sampled at edge t:
  - Latch in_a, in_b and the op.
  - Load counter = MULT_CYCLES-1 (mult/multu) or DIV_CYCLES-1 (div/divu).
  - Go to RUN; busy=1 from edge t.
- RUN, counter≠0: decrement each edge. hi/lo keep their previous values.
- RUN, counter=0, at edge t+N (N = selected latency):
  - Write hi/lo with the result of the latched operands.
  - Return to IDLE; busy=0 from the same edge.
  - New hi/lo are visible in the cycle busy first reads 0.
- Back-to-back requests:
  - A new start is accepted in the cycle after busy falls.
  - start in the same cycle busy falls is not possible, because busy is still 1 during that cycle.
- start while busy=1 is ignored. This covers all ops, including mthi/mtlo; upstream must stall.
- IDLE, start=1, MDUOp=5: hi ← in_a at the next edge. MDUOp=6: lo ← in_a. busy stays 0.
- start=1 with MDUOp 0 or 7: no effect.
- Operands are sampled only at acceptance; later changes on in_a/in_b do not affect the result.
- mult: signed 2W-bit product; hi = upper W bits, lo = lower W bits.
- multu: same as mult, unsigned.
- div: signed; quotient truncates toward zero; remainder has the sign of the dividend; lo = quotient, hi = remainder.
  - Overflow case (in_a = most-negative, in_b = -1): lo = most-negative, hi = 0.
- divu: unsigned; lo = quotient, hi = remainder.
- Divide by zero (in_b=0 for div/divu): the full DIV_CYCLES busy period still runs; hi/lo are left unchanged at completion.
- Arithmetic must be exact for any WIDTH ≥ 2. The counter width is sized for max(MULT_CYCLES, DIV_CYCLES).

Test Plan:
- Reset, then start=1, MDUOp=1, in_a=0xFFFFFFFE (-2), in_b=3:
  - busy=1 for exactly 5 cycles.
  - At completion hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo stay 0 while busy.
- multu, in_a=0xFFFFFFFF, in_b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div, in_a=-7, in_b=2 → busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then:
  - divu 7/0 → hi/lo unchanged after 10 busy cycles.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi with in_a=0x12345678 → hi=0x12345678 next cycle, busy never asserts. Then mult 2×3, and during busy:
  - Issue mtlo with in_a=0xDEAD and a second mult.
  - Both are ignored; final lo=6, hi=0.
- mult accepted, reset asserted on the 3rd busy cycle → busy=0, hi=lo=0 next edge. The cycle after reset drops, a mult 4×5 is accepted and gives lo=20 after 5 cycles.
- Re-elaborate with WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3:
  - mult 0x80×0x80 → busy for one cycle, hi=0x40, lo=0x00.
  - divu 200/7 → after 3 cycles lo=28, hi=4.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the HI/LO pair.
// A mult/multu/div/divu accepted in IDLE latches its operands. The unit then
// counts down its fixed latency in RUN and writes HI/LO on the final edge.
// mthi/mtlo write HI/LO directly from IDLE and never raise busy.
//
// Handshake: a request is qualified by start=1 and is accepted only on an
// edge where busy=0. While busy=1 every request, including mthi/mtlo, is
// dropped, so upstream must hold off until busy reads 0. busy comes straight
// from the state register and has no combinational path from start.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quot, rem;

    // Products and quotient/remainder of the latched operands. The signed
    // product is the low 2W bits of the sign-extended product. The signed
    // divide works on magnitudes and then restores the signs: the quotient
    // truncates toward zero and the remainder takes the dividend's sign.
    // The overflow case (most-negative / -1) falls out as most-negative / 0.
    always_comb begin
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        neg_a  = (op_q == OP_DIV) && a_q[WIDTH-1];
        neg_b  = (op_q == OP_DIV) && b_q[WIDTH-1];
        mag_a  = neg_a ? -a_q : a_q;
        mag_b  = neg_b ? -b_q : b_q;
        q_mag  = '0;
        r_mag  = '0;
        if (mag_b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem    = neg_a ? -r_mag : r_mag;
    end

    // Next-state logic: accept requests in IDLE, count down in RUN, and write
    // the result on the last RUN edge. A zero divisor leaves HI/LO as they are.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            a_d     = in_a;
                            b_d     = in_b;
                            op_d    = op_t'(MDUOp);
                            cnt_d   = MULT_LOAD;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = in_a;
                            b_d     = in_b;
                            op_d    = op_t'(MDUOp);
                            cnt_d   = DIV_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = in_a;
                        OP_MTLO: lo_d = in_a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, latched operands and HI/LO. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
